// File: rtl/keypad_entry.sv
// Keypad scanner with press/release debounce and a 4-digit decimal entry
// accumulator. Columns are driven one-cold; rows are read back through a
// 2-flop synchronizer. Accepted keys feed a small entry editor
// (digits, clear, backspace, enter).
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CNT = 200,
    parameter int unsigned DWELL        = 4
) (
    input  logic        scan_clk,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [12:0] entry_bin,
    output logic [2:0]  digit_cnt,
    output logic [12:0] num_bin,
    output logic        num_valid,
    output logic        err
);

    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned DWL_W     = $clog2(DWELL);
    localparam int unsigned ENTRY_MAX = 8191;

    localparam logic [1:0] SCAN      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] DEB_REL   = 2'd3;

    logic [3:0]       sync_q, rows_s;
    logic [1:0]       state, state_d;
    logic [1:0]       col_idx, col_idx_d;
    logic [DWL_W-1:0] dwell_cnt, dwell_d;
    logic [DEB_W-1:0] deb_cnt, deb_d, deb_inc;
    logic             deb_done;
    logic [1:0]       cap_row, cap_row_d;
    logic [3:0]       cap_pat, cap_pat_d;
    logic             hit;
    logic [1:0]       hit_row;
    logic [3:0]       col_out_d;
    logic             key_valid_d;
    logic [3:0]       key_code_d;
    logic [12:0]      entry_d, num_d;
    logic [2:0]       cnt_d;
    logic             num_valid_d, err_d;
    logic [16:0]      prod;

    // Key legend lookup by (row, column).
    function automatic logic [3:0] code_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge scan_clk) begin
        if (reset) begin
            sync_q <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            sync_q <= row_in;
            rows_s <= sync_q;
        end
    end

    // Single-row detection: exactly one row pulled low.
    always_comb begin
        hit     = 1'b1;
        hit_row = 2'd0;
        case (rows_s)
            4'b1110: hit_row = 2'd0;
            4'b1101: hit_row = 2'd1;
            4'b1011: hit_row = 2'd2;
            4'b0111: hit_row = 2'd3;
            default: hit = 1'b0;
        endcase
    end

    assign deb_inc  = deb_cnt + DEB_W'(1);
    assign deb_done = (deb_inc == DEB_W'(DEBOUNCE_CNT));

    // Scan / debounce next-state and key acceptance.
    always_comb begin
        state_d     = state;
        col_idx_d   = col_idx;
        dwell_d     = dwell_cnt;
        deb_d       = deb_cnt;
        cap_row_d   = cap_row;
        cap_pat_d   = cap_pat;
        key_valid_d = 1'b0;
        key_code_d  = key_code;
        case (state)
            SCAN: begin
                if (dwell_cnt == DWL_W'(DWELL - 1)) begin
                    dwell_d = '0;
                    if (hit) begin
                        state_d   = DEB_PRESS;
                        cap_row_d = hit_row;
                        cap_pat_d = rows_s;
                        deb_d     = '0;
                    end else begin
                        col_idx_d = col_idx + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_cnt + DWL_W'(1);
                end
            end
            DEB_PRESS: begin
                if (rows_s == cap_pat) begin
                    deb_d = deb_inc;
                    if (deb_done) begin
                        state_d     = HELD;
                        deb_d       = '0;
                        key_valid_d = 1'b1;
                        key_code_d  = code_lut(cap_row, col_idx);
                    end
                end else begin
                    state_d   = SCAN;
                    col_idx_d = col_idx + 2'd1;
                    dwell_d   = '0;
                    deb_d     = '0;
                end
            end
            HELD: begin
                if (rows_s == 4'hF) begin
                    state_d = DEB_REL;
                    deb_d   = '0;
                end
            end
            default: begin
                if (rows_s != 4'hF) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_inc;
                    if (deb_done) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx + 2'd1;
                        dwell_d   = '0;
                        deb_d     = '0;
                    end
                end
            end
        endcase
        col_out_d = ~(4'b0001 << col_idx_d);
    end

    // Entry editor, acting on the cycle after key_valid.
    always_comb begin
        entry_d     = entry_bin;
        cnt_d       = digit_cnt;
        num_d       = num_bin;
        num_valid_d = 1'b0;
        err_d       = 1'b0;
        prod        = 17'(entry_bin) * 17'd10 + 17'(key_code);
        if (key_valid) begin
            case (key_code)
                4'd10: begin
                    entry_d = '0;
                    cnt_d   = '0;
                end
                4'd11: begin
                    if (digit_cnt != 3'd0) begin
                        entry_d = entry_bin / 13'd10;
                        cnt_d   = digit_cnt - 3'd1;
                    end
                end
                4'd15: begin
                    if (digit_cnt != 3'd0) begin
                        num_d       = entry_bin;
                        num_valid_d = 1'b1;
                        entry_d     = '0;
                        cnt_d       = '0;
                    end
                end
                default: begin
                    if (key_code <= 4'd9) begin
                        if (digit_cnt < 3'd4 && prod <= 17'(ENTRY_MAX)) begin
                            entry_d = prod[12:0];
                            cnt_d   = digit_cnt + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge scan_clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            cap_row   <= 2'd0;
            cap_pat   <= 4'hF;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            entry_bin <= '0;
            digit_cnt <= '0;
            num_bin   <= '0;
            num_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            col_idx   <= col_idx_d;
            col_out   <= col_out_d;
            dwell_cnt <= dwell_d;
            deb_cnt   <= deb_d;
            cap_row   <= cap_row_d;
            cap_pat   <= cap_pat_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
            entry_bin <= entry_d;
            digit_cnt <= cnt_d;
            num_bin   <= num_d;
            num_valid <= num_valid_d;
            err       <= err_d;
        end
    end

endmodule
